// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if: request/response bundle of the sequential execute unit.
//
// Handshake: an operation is accepted on a rising clk edge where start=1 and
// busy=0 (busy acts as the inverted ready). Operation/SrcA/SrcB are sampled
// only at that edge. Each accepted operation yields exactly one cycle of
// done=1; ALUResult/BrTaken/Illegal are valid in that cycle and then held
// until the next completion.
//
// Signals:
//   start      master->slave  request
//   Operation  master->slave  4-bit operation code
//   SrcA       master->slave  operand A (PC for jal)
//   SrcB       master->slave  operand B (immediate for lui, shamt in low bits)
//   busy       slave->master  operation in flight, start ignored
//   done       slave->master  one-cycle completion pulse
//   ALUResult  slave->master  result, held between completions
//   BrTaken    slave->master  branch condition, held like ALUResult
//   Illegal    slave->master  completed code was the unused code 1001
//   state_dbg  slave->master  FSM state (0 = IDLE, 1 = SHIFT)
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  BrTaken;
    logic                  Illegal;
    logic                  state_dbg;

    modport master (
        output start, Operation, SrcA, SrcB,
        input  busy, done, ALUResult, BrTaken, Illegal, state_dbg
    );

    modport slave (
        input  start, Operation, SrcA, SrcB,
        output busy, done, ALUResult, BrTaken, Illegal, state_dbg
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: sequential execute unit for the RISC-V datapath.
//
// Arithmetic, logic, compare, branch, lui and jal codes complete one cycle
// after acceptance. Shifts use an iterative one-bit-per-cycle shifter
// (latency shamt+1), unless ALU_SEQ_FAST_SHIFT_EN is defined, in which case a
// barrel shifter gives every code latency 1, busy stays 0 and no SHIFT state
// exists. Results are identical in both builds.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts an in-flight shift, no done
//   bus    alu_seq_if.slave (start/Operation/SrcA/SrcB in,
//          busy/done/ALUResult/BrTaken/Illegal/state_dbg out)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_BLT = 4'b1011;
    localparam logic [3:0] OP_BGE = 4'b1100;
    localparam logic [3:0] OP_BEQ = 4'b1101;
    localparam logic [3:0] OP_LUI = 4'b1110;
    localparam logic [3:0] OP_JAL = 4'b1111;

    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] comb_res;
    logic                  comb_br;
    logic                  comb_ill;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  br_q;
    logic                  ill_q;
    logic                  done_q;
    logic                  busy;

    assign shamt = bus.SrcB[SHW-1:0];

    // Single-cycle result for everything the unit can finish at acceptance.
    always_comb begin
        comb_res = '0;
        comb_br  = 1'b0;
        comb_ill = 1'b0;
        case (bus.Operation)
            OP_ADD: comb_res = bus.SrcA + bus.SrcB;
            OP_SUB: comb_res = bus.SrcA - bus.SrcB;
            OP_XOR: comb_res = bus.SrcA ^ bus.SrcB;
            OP_OR:  comb_res = bus.SrcA | bus.SrcB;
            OP_AND: comb_res = bus.SrcA & bus.SrcB;
            OP_SLT: comb_res = {{(DATA_WIDTH-1){1'b0}},
                                ($signed(bus.SrcA) < $signed(bus.SrcB))};
`ifdef ALU_SEQ_FAST_SHIFT_EN
            OP_SRA: comb_res = $unsigned($signed(bus.SrcA) >>> shamt);
            OP_SRL: comb_res = bus.SrcA >> shamt;
            OP_SLL: comb_res = bus.SrcA << shamt;
`else
            // Only used when shamt is zero; longer shifts go through SHIFT.
            OP_SRA, OP_SRL, OP_SLL: comb_res = bus.SrcA;
`endif
            OP_BNE: begin
                comb_br  = (bus.SrcA != bus.SrcB);
                comb_res = {{(DATA_WIDTH-1){1'b0}}, comb_br};
            end
            OP_BLT: begin
                comb_br  = ($signed(bus.SrcA) < $signed(bus.SrcB));
                comb_res = {{(DATA_WIDTH-1){1'b0}}, comb_br};
            end
            OP_BGE: begin
                comb_br  = ($signed(bus.SrcA) >= $signed(bus.SrcB));
                comb_res = {{(DATA_WIDTH-1){1'b0}}, comb_br};
            end
            OP_BEQ: begin
                comb_br  = (bus.SrcA == bus.SrcB);
                comb_res = {{(DATA_WIDTH-1){1'b0}}, comb_br};
            end
            OP_LUI: comb_res = bus.SrcB;
            OP_JAL: comb_res = bus.SrcA + DATA_WIDTH'(4);
            default: comb_ill = 1'b1;   // 1001, the unused code
        endcase
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_n;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] sh_reg;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [SHW-1:0]        cnt;
    logic [3:0]            sh_op;

    assign is_shift = (bus.Operation == OP_SRA) || (bus.Operation == OP_SRL) ||
                      (bus.Operation == OP_SLL);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.start && is_shift && (shamt != '0)) begin
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state == S_SHIFT);
    end

    assign bus.state_dbg = state;

    // One-bit step of the latched shift operation.
    always_comb begin
        case (sh_op)
            OP_SLL:  sh_next = {sh_reg[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_reg[DATA_WIDTH-1:1]};
            default: sh_next = {sh_reg[DATA_WIDTH-1], sh_reg[DATA_WIDTH-1:1]};
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_reg <= '0;
            cnt    <= '0;
            sh_op  <= OP_ADD;
            res_q  <= '0;
            br_q   <= 1'b0;
            ill_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == S_SHIFT) begin
                sh_reg <= sh_next;
                cnt    <= cnt - SHW'(1);
                // The last step writes the fully shifted value directly.
                if (cnt == SHW'(1)) begin
                    res_q  <= sh_next;
                    br_q   <= 1'b0;
                    ill_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (bus.start) begin
                if (is_shift && (shamt != '0)) begin
                    sh_reg <= bus.SrcA;
                    cnt    <= shamt;
                    sh_op  <= bus.Operation;
                end else begin
                    res_q  <= comb_res;
                    br_q   <= comb_br;
                    ill_q  <= comb_ill;
                    done_q <= 1'b1;
                end
            end
        end
    end
`else
    // Barrel-shifter build: every code completes at acceptance.
    assign busy          = 1'b0;
    assign bus.state_dbg = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q  <= '0;
            br_q   <= 1'b0;
            ill_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                res_q  <= comb_res;
                br_q   <= comb_br;
                ill_q  <= comb_ill;
                done_q <= 1'b1;
            end
        end
    end
`endif

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.ALUResult = res_q;
    assign bus.BrTaken   = br_q;
    assign bus.Illegal   = ill_q;

endmodule
